// File: rtl/game_state_ctrl_pkg.sv
// Shared definitions for the raccoon crossing game sequencer: state encodings,
// field widths and the playfield constants also used by the controller and VGA overlay.
package game_state_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_HIT       = 3'd2,
    ST_LEVEL_UP  = 3'd3,
    ST_GAME_OVER = 3'd4
  } game_state_t;

  localparam int LIVES_W = 2;
  localparam int LEVEL_W = 3;
  localparam int SPEED_W = 4;
  localparam int TIMER_W = 8;
  localparam int Y_W     = 10;

  localparam int GOAL_Y_ROW = 0;
  localparam int START_X    = 312;
  localparam int START_Y    = 464;

  // Obstacle speed tracks the level, offset so level 0 still moves.
  function automatic logic [SPEED_W-1:0] level_to_speed(input logic [LEVEL_W-1:0] level);
    return {1'b0, level} + SPEED_W'(1);
  endfunction

  function automatic logic [LIVES_W-1:0] lives_after_hit(input logic [LIVES_W-1:0] lives);
    return (lives == '0) ? '0 : lives - LIVES_W'(1);
  endfunction

endpackage

// File: rtl/game_frame_timer.sv
// Frame counter shared by the HIT and LEVEL_UP freezes; done fires on the
// tick that completes the target count.
module game_frame_timer
  import game_state_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               tick,
  input  logic [TIMER_W-1:0] target,
  output logic               done
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + TIMER_W'(1);
    end
  end

  // Comparing against target-1 lets the exiting tick itself be the Nth one.
  assign done = tick && (count == target - TIMER_W'(1));

endmodule

// File: rtl/game_state_ctrl.sv
// Game sequencer: gates raccoon movement, tracks lives and level, and times
// hit / level-complete freezes in video frames.
module game_state_ctrl
  import game_state_ctrl_pkg::*;
#(
  parameter int LIVES_INIT = 3,
  parameter int GOAL_Y     = GOAL_Y_ROW,
  parameter int HIT_FRAMES = 60,
  parameter int WIN_FRAMES = 120,
  parameter int MAX_LEVEL  = 7
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Frame_Tick,
  input  logic               i_Any_Button,
  input  logic [Y_W-1:0]     i_Raccoon_Y,
  input  logic               i_Collision,
  output logic               o_Move_En,
  output logic               o_Respawn,
  output logic [2:0]         o_State,
  output logic [LIVES_W-1:0] o_Lives,
  output logic [LEVEL_W-1:0] o_Level,
  output logic [SPEED_W-1:0] o_Speed
);

  game_state_t          state;
  logic [LIVES_W-1:0]   lives;
  logic [LEVEL_W-1:0]   level;
  logic                 btn_prev;
  logic                 move_en;
  logic                 respawn;

  logic                 press;
  logic                 at_goal;
  logic                 frozen;
  logic                 timer_tick;
  logic                 timer_done;
  logic [TIMER_W-1:0]   timer_target;

  assign press   = i_Any_Button && !btn_prev;
  assign at_goal = (i_Raccoon_Y == Y_W'(GOAL_Y));
  assign frozen  = (state == ST_HIT) || (state == ST_LEVEL_UP);

  // Timer is held clear outside the freezes, so it starts from zero on the
  // entering edge and a tick arriving in that cycle is never counted.
  assign timer_tick   = i_Frame_Tick && frozen;
  assign timer_target = (state == ST_HIT) ? TIMER_W'(HIT_FRAMES) : TIMER_W'(WIN_FRAMES);

  game_frame_timer u_frame_timer (
    .clk    (i_Clk),
    .rst    (i_Rst),
    .clear  (!frozen),
    .tick   (timer_tick),
    .target (timer_target),
    .done   (timer_done)
  );

  // o_Respawn and o_Move_En are registered alongside the state so every
  // output changes on the same edge as the decision that drives it.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state    <= ST_IDLE;
      lives    <= LIVES_W'(LIVES_INIT);
      level    <= '0;
      btn_prev <= 1'b1;
      move_en  <= 1'b0;
      respawn  <= 1'b0;
    end else begin
      btn_prev <= i_Any_Button;
      respawn  <= 1'b0;
      move_en  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (press) begin
            state   <= ST_PLAY;
            lives   <= LIVES_W'(LIVES_INIT);
            level   <= '0;
            respawn <= 1'b1;
            move_en <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (i_Collision) begin
            state <= ST_HIT;
            lives <= lives_after_hit(lives);
          end else if (at_goal) begin
            state <= ST_LEVEL_UP;
          end else begin
            move_en <= 1'b1;
          end
        end
        ST_HIT: begin
          if (timer_done) begin
            if (lives == '0) begin
              state <= ST_GAME_OVER;
            end else begin
              state   <= ST_PLAY;
              respawn <= 1'b1;
              move_en <= 1'b1;
            end
          end
        end
        ST_LEVEL_UP: begin
          if (timer_done) begin
            if (level < LEVEL_W'(MAX_LEVEL)) begin
              level <= level + LEVEL_W'(1);
            end
            state   <= ST_PLAY;
            respawn <= 1'b1;
            move_en <= 1'b1;
          end
        end
        ST_GAME_OVER: begin
          lives <= '0;
          if (press) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_Move_En = move_en;
  assign o_Respawn = respawn;
  assign o_State   = state;
  assign o_Lives   = lives;
  assign o_Level   = level;
  assign o_Speed   = level_to_speed(level);

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: directed scenarios with literal
// expectations, then randomized play against a behavioural reference model.
module tb_game_state_ctrl;

  localparam int LIVES_INIT = 3;
  localparam int GOAL_Y     = 0;
  localparam int HIT_FRAMES = 4;
  localparam int WIN_FRAMES = 2;
  localparam int MAX_LEVEL  = 7;
  localparam int NORMAL_Y   = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       btn = 1'b1;
  logic [9:0] y = 10'(NORMAL_Y);
  logic       coll = 1'b0;

  logic       move_en;
  logic       respawn;
  logic [2:0] state;
  logic [1:0] lives;
  logic [2:0] level;
  logic [3:0] speed;

  int checks = 0;
  int errors = 0;

  game_state_ctrl #(
    .LIVES_INIT (LIVES_INIT),
    .GOAL_Y     (GOAL_Y),
    .HIT_FRAMES (HIT_FRAMES),
    .WIN_FRAMES (WIN_FRAMES),
    .MAX_LEVEL  (MAX_LEVEL)
  ) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Frame_Tick (tick),
    .i_Any_Button (btn),
    .i_Raccoon_Y  (y),
    .i_Collision  (coll),
    .o_Move_En    (move_en),
    .o_Respawn    (respawn),
    .o_State      (state),
    .o_Lives      (lives),
    .o_Level      (level),
    .o_Speed      (speed)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Modes: 0 idle, 1 playing, 2 hit freeze, 3 level freeze, 4 game over.
  int mode = 0;
  int prev_mode = 0;
  int m_lives = 0;
  int m_level = 0;
  int frames_left = 0;
  bit last_btn = 1'b1;
  bit m_valid = 1'b0;
  bit pressed;

  always @(posedge clk) begin
    pressed   = btn && !last_btn;
    prev_mode = mode;
    if (rst) begin
      mode        = 0;
      prev_mode   = 0;
      m_lives     = LIVES_INIT;
      m_level     = 0;
      frames_left = 0;
      last_btn    = 1'b1;
      m_valid     = 1'b1;
    end else begin
      last_btn = btn;
      if (mode == 0) begin
        if (pressed) begin
          mode = 1; m_lives = LIVES_INIT; m_level = 0;
        end
      end else if (mode == 1) begin
        if (coll) begin
          mode = 2;
          m_lives = (m_lives > 0) ? m_lives - 1 : 0;
          frames_left = HIT_FRAMES;
        end else if (y == 10'(GOAL_Y)) begin
          mode = 3;
          frames_left = WIN_FRAMES;
        end
      end else if (mode == 2) begin
        if (tick) begin
          frames_left--;
          if (frames_left == 0) mode = (m_lives == 0) ? 4 : 1;
        end
      end else if (mode == 3) begin
        if (tick) begin
          frames_left--;
          if (frames_left == 0) begin
            mode = 1;
            if (m_level < MAX_LEVEL) m_level++;
          end
        end
      end else begin
        if (pressed) mode = 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_state",   int'(state),   mode);
      chk("model_lives",   int'(lives),   m_lives);
      chk("model_level",   int'(level),   m_level);
      chk("model_speed",   int'(speed),   m_level + 1);
      chk("model_move_en", int'(move_en), int'(mode == 1));
      chk("model_respawn", int'(respawn), int'(mode == 1 && prev_mode != 1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // One counted frame tick followed by idle cycles (ticks kept >= 2 apart).
  task automatic frame_tick();
    tick = 1'b1; step();
    tick = 1'b0; step(2);
  endtask

  int since_tick = 0;

  // ---------------- stimulus ----------------
  initial begin
    // Reset with the button held: no start while held.
    rst = 1'b1; btn = 1'b1; step(2);
    rst = 1'b0; step(3);
    chk("held_no_start", int'(state), 0);
    chk("reset_move_en", int'(move_en), 0);
    btn = 1'b0; step();
    btn = 1'b1; step();
    chk("start_state", int'(state), 1);
    chk("start_respawn", int'(respawn), 1);
    chk("start_lives", int'(lives), 3);
    chk("start_level", int'(level), 0);
    chk("start_speed", int'(speed), 1);
    btn = 1'b0; step();
    chk("start_respawn_end", int'(respawn), 0);

    // Collision with a tick in the entry cycle (not counted).
    coll = 1'b1; tick = 1'b1; step();
    coll = 1'b0; tick = 1'b0;
    chk("hit_state", int'(state), 2);
    chk("hit_move_en", int'(move_en), 0);
    chk("hit_lives", int'(lives), 2);
    step(2);
    repeat (3) frame_tick();
    chk("hit_hold_3_ticks", int'(state), 2);
    tick = 1'b1; step();
    chk("hit_exit_state", int'(state), 1);
    chk("hit_exit_respawn", int'(respawn), 1);
    tick = 1'b0; step();
    chk("hit_exit_respawn_end", int'(respawn), 0);

    // Goal and collision together: collision wins.
    y = 10'(GOAL_Y); coll = 1'b1; step();
    y = 10'(NORMAL_Y); coll = 1'b0;
    chk("both_state", int'(state), 2);
    chk("both_lives", int'(lives), 1);
    repeat (3) frame_tick();
    tick = 1'b1; step(); tick = 1'b0; step();

    // Third collision leads to game over.
    coll = 1'b1; step(); coll = 1'b0;
    chk("last_hit_lives", int'(lives), 0);
    repeat (3) frame_tick();
    tick = 1'b1; step(); tick = 1'b0;
    chk("game_over_state", int'(state), 4);
    chk("game_over_respawn", int'(respawn), 0);
    chk("game_over_lives", int'(lives), 0);
    step(2);
    btn = 1'b1; step();
    chk("over_to_idle", int'(state), 0);
    btn = 1'b0; step();
    btn = 1'b1; step();
    chk("restart_state", int'(state), 1);
    chk("restart_lives", int'(lives), 3);
    btn = 1'b0; step();

    // Nine goals: level climbs to 7 and saturates.
    for (int i = 1; i <= 9; i++) begin
      y = 10'(GOAL_Y); step(); y = 10'(NORMAL_Y);
      chk("goal_state", int'(state), 3);
      frame_tick();
      tick = 1'b1; step(); tick = 1'b0;
      chk("goal_exit_state", int'(state), 1);
      chk("goal_level", int'(level), (i < 7) ? i : 7);
      chk("goal_respawn", int'(respawn), 1);
      step(2);
    end
    chk("max_speed", int'(speed), 8);

    // Reset mid level-up after one of two ticks.
    y = 10'(GOAL_Y); step(); y = 10'(NORMAL_Y);
    frame_tick();
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_state", int'(state), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_lives", int'(lives), 3);
    chk("rst_move_en", int'(move_en), 0);
    repeat (3) frame_tick();
    chk("rst_ticks_ignored", int'(state), 0);

    // Randomized play against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) == 0) btn = ~btn;
      coll = ($urandom_range(0, 19) == 0);
      y = ($urandom_range(0, 14) == 0) ? 10'(GOAL_Y) : 10'($urandom_range(1, 479));
      if (since_tick >= 2 && $urandom_range(0, 2) == 0) begin
        tick = 1'b1; since_tick = 0;
      end else begin
        tick = 1'b0; since_tick++;
      end
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0; tick = 1'b0; coll = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
